// File: rtl/wb_can_bridge_if.sv
// Signal bundle between the debug-bus master, the bridge and the CAN register port.
// The bridge uses the slave modport; the environment driving both sides uses master.
interface wb_can_bridge_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic [31:0] o_wb_data;
    logic        o_can_cyc;
    logic        o_can_stb;
    logic        o_can_we;
    logic [7:0]  o_can_addr;
    logic [7:0]  o_can_dat;
    logic [7:0]  i_can_dat;
    logic        i_can_ack;
    logic        i_can_irq_n;
    logic        o_irq;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
        output o_can_cyc, o_can_stb, o_can_we, o_can_addr, o_can_dat,
        input  i_can_dat, i_can_ack, i_can_irq_n,
        output o_irq
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
        input  o_can_cyc, o_can_stb, o_can_we, o_can_addr, o_can_dat,
        output i_can_dat, i_can_ack, i_can_irq_n,
        input  o_irq
    );
endinterface

// File: rtl/wb_can_bridge.sv
// Bridges 32-bit pipelined debug-bus accesses onto the CAN core's 8-bit register port,
// turning out-of-window, timed-out or missing responses into bus errors.
module wb_can_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0001,
    parameter int          WINDOW       = 256,
    parameter int          TIMEOUT_CLKS = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    wb_can_bridge_if.slave   bus
);
    localparam int            CW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [32:0]   WIN      = 33'(WINDOW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_r,    state_s;
    logic [CW-1:0] cnt_r,      cnt_s;
    logic          stall_r,    stall_s;
    logic          ack_r,      ack_s;
    logic          err_r,      err_s;
    logic [31:0]   wb_data_r,  wb_data_s;
    logic          can_cyc_r,  can_cyc_s;
    logic          can_stb_r,  can_stb_s;
    logic          can_we_r,   can_we_s;
    logic [7:0]    can_addr_r, can_addr_s;
    logic [7:0]    can_dat_r,  can_dat_s;
    logic          irq_r;
    logic [31:0]   off_s;

    // Next-state and next-output computation for the access sequencer
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stall_s    = stall_r;
        ack_s      = 1'b0;
        err_s      = 1'b0;
        wb_data_s  = 32'h0000_0000;
        can_cyc_s  = can_cyc_r;
        can_stb_s  = can_stb_r;
        can_we_s   = can_we_r;
        can_addr_s = can_addr_r;
        can_dat_s  = can_dat_r;
        // Unsigned subtraction: addresses below the base wrap to huge offsets.
        off_s      = bus.i_wb_addr - BASE_ADDR;
        case (state_r)
            IDLE: begin
                stall_s = 1'b0;
                if (bus.i_wb_cyc && bus.i_wb_stb && !stall_r) begin
                    stall_s = 1'b1;
                    if ({1'b0, off_s} < WIN) begin
                        state_s    = ACCESS;
                        can_addr_s = off_s[7:0];
                        can_dat_s  = bus.i_wb_data[7:0];
                        can_we_s   = bus.i_wb_we;
                        can_cyc_s  = 1'b1;
                        can_stb_s  = 1'b1;
                        cnt_s      = {CW{1'b0}};
                    end else begin
                        state_s = RESP;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // Master abort outranks a late CAN ack; nothing is reported back.
                if (!bus.i_wb_cyc) begin
                    state_s   = IDLE;
                    stall_s   = 1'b0;
                    can_cyc_s = 1'b0;
                    can_stb_s = 1'b0;
                end else if (bus.i_can_ack) begin
                    state_s   = RESP;
                    ack_s     = 1'b1;
                    wb_data_s = can_we_r ? 32'h0000_0000 : {24'h00_0000, bus.i_can_dat};
                    can_cyc_s = 1'b0;
                    can_stb_s = 1'b0;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = RESP;
                    err_s     = 1'b1;
                    can_cyc_s = 1'b0;
                    can_stb_s = 1'b0;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r;
                end
            end
            RESP: begin
                state_s = IDLE;
                stall_s = 1'b0;
            end
            default: begin
                state_s   = IDLE;
                stall_s   = 1'b0;
                can_cyc_s = 1'b0;
                can_stb_s = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            stall_r    <= 1'b0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            wb_data_r  <= 32'h0000_0000;
            can_cyc_r  <= 1'b0;
            can_stb_r  <= 1'b0;
            can_we_r   <= 1'b0;
            can_addr_r <= 8'h00;
            can_dat_r  <= 8'h00;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            stall_r    <= stall_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
            wb_data_r  <= wb_data_s;
            can_cyc_r  <= can_cyc_s;
            can_stb_r  <= can_stb_s;
            can_we_r   <= can_we_s;
            can_addr_r <= can_addr_s;
            can_dat_r  <= can_dat_s;
        end
    end

    // Interrupt resynchronised and inverted, independent of the sequencer
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= !bus.i_can_irq_n;
        end
    end

    assign bus.o_wb_stall = stall_r;
    assign bus.o_wb_ack   = ack_r;
    assign bus.o_wb_err   = err_r;
    assign bus.o_wb_data  = wb_data_r;
    assign bus.o_can_cyc  = can_cyc_r;
    assign bus.o_can_stb  = can_stb_r;
    assign bus.o_can_we   = can_we_r;
    assign bus.o_can_addr = can_addr_r;
    assign bus.o_can_dat  = can_dat_r;
    assign bus.o_irq      = irq_r;
endmodule
